button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 71 +++++++
 tb/tb_button_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-button sync, debounce, active-high level, press/release strobes, hold-to-repeat (clk_clk, reset_reset, key_in -> btn_level, btn_press, btn_release)
module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [N_BUTTONS-1:0] key_in,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(RMAX > 2 ? RMAX : 2);
  localparam logic [1:0] RELEASED = 2'd0, HELD = 2'd1, REPEAT = 2'd2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LD = TW'(REPEAT_PERIOD - 1);
  localparam logic IDLE_PIN = 1'(ACTIVE_LOW);
  localparam logic RPT_EN = REPEAT_DELAY != 0;
  for (genvar g = 0; g < N_BUTTONS; g++) begin : ch
    logic s1, s2, raw, accept, lvl, prs, rls;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic [1:0] st;
    assign raw = s2 ^ IDLE_PIN;
    assign accept = raw != lvl && cnt == CNT_MAX;
    assign btn_level[g] = lvl;
    assign btn_press[g] = prs;
    assign btn_release[g] = rls;
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        s1 <= IDLE_PIN;
        s2 <= IDLE_PIN;
        cnt <= '0;
        tmr <= '0;
        st <= RELEASED;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        s1 <= key_in[g];
        s2 <= s1;
        cnt <= (raw == lvl || accept) ? '0 : cnt + 1'b1;
        prs <= 1'b0;
        rls <= 1'b0;
        if (accept) lvl <= raw;
        if (accept && !raw) begin
          st <= RELEASED;
          rls <= 1'b1;
        end else if (accept && raw) begin
          st <= HELD;
          prs <= 1'b1;
          tmr <= DLY_LD;
        end else if ((st == HELD && RPT_EN) || st == REPEAT) begin
          if (tmr == '0) begin
            st <= REPEAT;
            prs <= 1'b1;
            tmr <= PER_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus, timeline model and literal checks for button_conditioner
module tb_button_conditioner;
  localparam int N = 4, DC = 4, RD = 8, RP = 3;
  logic clk_clk = 1'b0, reset_reset = 1'b1;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] a_level, a_press, a_release, b_level, b_press, b_release;
  int n_chk = 0, n_fail = 0;
  always #5 clk_clk = ~clk_clk;
  button_conditioner #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .REPEAT_DELAY(0)) dut_a (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .key_in(key_in),
    .btn_level(a_level), .btn_press(a_press), .btn_release(a_release));
  button_conditioner #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .key_in(key_in),
    .btn_level(b_level), .btn_press(b_press), .btn_release(b_release));
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #2;
  endtask
  logic rst_h [0:8191];
  logic [N-1:0] prs_h [0:8191];
  int t = 0;
  int tp [N];
  logic [N-1:0] m_lvl = '0, ma_press = '0, mb_press = '0, m_rel = '0;
  logic flip;
  int d;
  function automatic logic raw_at(input int k, input int i);
    if (k < 2) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return prs_h[k-2][i];
  endfunction
  always @(posedge clk_clk) begin
    rst_h[t] = reset_reset;
    prs_h[t] = ~key_in;
    for (int i = 0; i < N; i++) begin
      ma_press[i] = 1'b0;
      mb_press[i] = 1'b0;
      m_rel[i] = 1'b0;
      if (reset_reset) begin
        m_lvl[i] = 1'b0;
      end else begin
        flip = t >= DC - 1;
        for (int j = 0; j < DC; j++)
          if (flip) flip = !rst_h[t-j] && raw_at(t - j, i) != m_lvl[i];
        if (flip) begin
          m_lvl[i] = ~m_lvl[i];
          ma_press[i] = m_lvl[i];
          mb_press[i] = m_lvl[i];
          m_rel[i] = ~m_lvl[i];
          if (m_lvl[i]) tp[i] = t;
        end else if (m_lvl[i]) begin
          d = t - tp[i];
          mb_press[i] = d == RD || (d > RD && (d - RD) % RP == 0);
        end
      end
    end
    t++;
    #1;
    chk("a_level", a_level, m_lvl);
    chk("a_press", a_press, ma_press);
    chk("a_release", a_release, m_rel);
    chk("b_level", b_level, m_lvl);
    chk("b_press", b_press, mb_press);
    chk("b_release", b_release, m_rel);
  end
  int rel_seen, press_after;
  initial begin
    step(3);
    chk("rst_level", a_level | b_level, '0);
    chk("rst_strobes", a_press | a_release | b_press | b_release, '0);
    @(negedge clk_clk) reset_reset = 1'b0;
    step(3);
    @(negedge clk_clk) key_in[0] = 1'b0;
    step(5);
    chk("t1_early", a_level, 4'b0000);
    step(1);
    chk("t1_level", a_level, 4'b0001);
    chk("t1_press", a_press, 4'b0001);
    step(1);
    chk("t1_one_cycle", a_press, 4'b0000);
    foreach (key_in[k]) if (k >= 0) begin end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_clk) key_in[1] = k[0];
      repeat (2) @(posedge clk_clk);
      #2;
      chk("t2_bounce_level", a_level, 4'b0001);
      chk("t2_bounce_press", a_press | a_release, 4'b0000);
    end
    @(negedge clk_clk) key_in[1] = 1'b0;
    step(5);
    chk("t2_early", a_level, 4'b0001);
    step(1);
    chk("t2_level", a_level, 4'b0011);
    chk("t2_press", a_press, 4'b0010);
    @(negedge clk_clk) key_in[2] = 1'b0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk) key_in[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("t3_glitch", N'({a_level[2], a_press[2], a_release[2]}), '0);
    end
    @(negedge clk_clk) key_in[0] = 1'b1;
    step(5);
    chk("t4_early", a_level, 4'b0011);
    step(1);
    chk("t4_level", a_level, 4'b0010);
    chk("t4_release", a_release, 4'b0001);
    chk("t4_no_press", a_press, 4'b0000);
    step(1);
    chk("t4_one_cycle", a_release, 4'b0000);
    @(negedge clk_clk) key_in[3] = 1'b0;
    step(5);
    for (int k = 0; k < 16; k++) begin
      step(1);
      chk("t5_repeat", N'(b_press[3]), N'(k == 0 || k == 8 || k == 11 || k == 14));
    end
    @(negedge clk_clk) key_in[3] = 1'b1;
    rel_seen = 0;
    press_after = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (b_release[3]) rel_seen++;
      if (rel_seen > 0 && b_press[3]) press_after++;
    end
    chk_i("t5_release_count", rel_seen, 1);
    chk_i("t5_press_after_release", press_after, 0);
    @(negedge clk_clk) key_in[0] = 1'b0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk) reset_reset = 1'b1;
    step(1);
    chk("t6_rst_level", a_level | b_level, '0);
    chk("t6_rst_strobes", a_press | a_release | b_press | b_release, '0);
    @(negedge clk_clk) reset_reset = 1'b0;
    step(5);
    chk("t6_early", a_level, 4'b0000);
    step(1);
    chk("t6_level", a_level, 4'b0011);
    chk("t6_press", a_press, 4'b0011);
    @(negedge clk_clk) key_in = '1;
    step(12);
    chk("final_level", a_level | b_level, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
